// File: rtl/mem_copy_engine.sv
// mem_copy_engine: byte-wise block copy initiator for a single DataMemory instance.
//
// Reads LEN bytes starting at SRC and writes them to DST, one byte per
// read/wait/write sequence, in strict forward order. Writes become visible to
// later reads, so overlapping regions behave like a forward memmove.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start, i_abort        copy request (accepted only when idle) / stop request (only while busy)
//   i_src_addr, i_dst_addr  first source / destination address, latched on accepted start
//   i_length                byte count 0..2^ADDR_WIDTH, latched on accepted start
//   o_busy, o_done          copy in progress / one-cycle end-of-copy pulse
//   o_aborted               copy ended by abort; held until the next accepted start
//   o_words_copied          write cycles issued in the current or last copy
//   o_mem_*                 DataMemory address, read/write strobes and write data
//   i_mem_data_outputs      DataMemory read data
module mem_copy_engine #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted,
  output logic [ADDR_WIDTH:0]   o_words_copied,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data_inputs,
  input  logic [DATA_WIDTH-1:0] i_mem_data_outputs
);

  localparam int unsigned WaitW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WaitW-1:0]      WaitLast = WaitW'(READ_LATENCY - 1);
  localparam logic [WaitW-1:0]      WaitOne  = 1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = 1;
  localparam logic [ADDR_WIDTH:0]   CntOne   = 1;

  typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StDone} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_src_ptr;
  logic [ADDR_WIDTH-1:0] r_dst_ptr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [WaitW-1:0]      r_wait_cnt;

  // Single registered FSM: every output is loaded for the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state           <= StIdle;
      r_src_ptr         <= '0;
      r_dst_ptr         <= '0;
      r_remaining       <= '0;
      r_wait_cnt        <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_aborted         <= 1'b0;
      o_words_copied    <= '0;
      o_mem_address     <= '0;
      o_mem_read        <= 1'b0;
      o_mem_write       <= 1'b0;
      o_mem_data_inputs <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_src_ptr      <= i_src_addr;
            r_dst_ptr      <= i_dst_addr;
            r_remaining    <= i_length;
            o_words_copied <= '0;
            o_aborted      <= 1'b0;
            if (i_length == '0) begin
              r_state <= StDone;
              o_done  <= 1'b1;
            end else begin
              r_state       <= StRd;
              o_busy        <= 1'b1;
              o_mem_read    <= 1'b1;
              o_mem_address <= i_src_addr;
            end
          end
        end

        StRd: begin
          // The read strobed this cycle completes in memory; only the capture is skipped.
          o_mem_read <= 1'b0;
          if (i_abort) begin
            r_state   <= StDone;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_aborted <= 1'b1;
          end else begin
            r_state    <= StWait;
            r_wait_cnt <= '0;
          end
        end

        StWait: begin
          if (i_abort) begin
            r_state   <= StDone;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_aborted <= 1'b1;
          end else if (r_wait_cnt == WaitLast) begin
            // The write-data register doubles as the byte buffer for the WR cycle.
            r_state           <= StWr;
            o_mem_write       <= 1'b1;
            o_mem_address     <= r_dst_ptr;
            o_mem_data_inputs <= i_mem_data_outputs;
          end else begin
            r_wait_cnt <= r_wait_cnt + WaitOne;
          end
        end

        StWr: begin
          // The write issued this cycle always counts, even when aborting.
          o_mem_write       <= 1'b0;
          o_mem_data_inputs <= '0;
          o_words_copied    <= o_words_copied + CntOne;
          r_src_ptr         <= r_src_ptr + AddrOne;
          r_dst_ptr         <= r_dst_ptr + AddrOne;
          r_remaining       <= r_remaining - CntOne;
          if (i_abort || (r_remaining == CntOne)) begin
            r_state   <= StDone;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_aborted <= i_abort;
          end else begin
            r_state       <= StRd;
            o_mem_read    <= 1'b1;
            o_mem_address <= r_src_ptr + AddrOne;
          end
        end

        StDone: begin
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

  localparam int MaxCyc = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] length;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [8:0] words_copied;
  logic [7:0] mem_address;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  always #5 clk = ~clk;

  mem_copy_engine #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (8),
    .READ_LATENCY(1)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_start           (start),
    .i_abort           (abort),
    .i_src_addr        (src_addr),
    .i_dst_addr        (dst_addr),
    .i_length          (length),
    .o_busy            (busy),
    .o_done            (done),
    .o_aborted         (aborted),
    .o_words_copied    (words_copied),
    .o_mem_address     (mem_address),
    .o_mem_read        (mem_read),
    .o_mem_write       (mem_write),
    .o_mem_data_inputs (mem_din),
    .i_mem_data_outputs(mem_dout)
  );

  // DataMemory model: synchronous write, one-cycle registered read.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_din;
    if (mem_read) mem_dout <= mem[mem_address];
  end

  int n_checks = 0;
  int n_errors = 0;
  int conc_bad = 0;
  int din_bad  = 0;
  int wr_mon   = 0;

  always @(negedge clk) begin
    if (mem_read && mem_write) conc_bad++;
    if (!mem_write && mem_din != 8'h00) din_bad++;
    if (mem_write) wr_mon++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  int g_done_n, g_busy_n, g_rd_n, g_wr_n;
  logic [8:0] g_words;
  logic       g_aborted;

  // Called at a negedge. Start is sampled at edge E; cycle n is the n-th cycle after E.
  // Abort / stray start are driven from the middle of cycle abort_at / pulse_at.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                          input int abort_at, input int pulse_at);
    g_done_n = -1; g_busy_n = 0; g_rd_n = 0; g_wr_n = 0;
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= MaxCyc; n++) begin
      @(negedge clk);
      if (busy) g_busy_n++;
      if (mem_read) g_rd_n++;
      if (mem_write) g_wr_n++;
      abort = (n == abort_at);
      if (n == pulse_at) begin
        start = 1'b1; src_addr = 8'h02; dst_addr = 8'h41; length = 9'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        g_done_n = n; g_words = words_copied; g_aborted = aborted;
        break;
      end
    end
    if (g_done_n < 0) begin
      n_checks++; n_errors++;
      $display("FAIL run_timeout: got no done expected done within %0d cycles", MaxCyc);
    end
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]      src;
    logic [7:0]      dst;
    logic [8:0]      len;
    int              exp_done;
    int              nexp;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs [5];
  int   busy_idle;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h02] = 8'h55; mem[8'h0A] = 8'hCC;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3;
    mem[8'h30] = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      mem[8'hA0 + i] = 8'(i + 1);
      mem[8'hB0 + i] = 8'hEE;
    end

    vecs[0] = '{src: 8'h02, dst: 8'h40, len: 9'd1, exp_done: 4,  nexp: 1,
                exp: {8'h00, 8'h00, 8'h00, 8'h55}};
    vecs[1] = '{src: 8'h10, dst: 8'h80, len: 9'd4, exp_done: 13, nexp: 4,
                exp: {8'h44, 8'h33, 8'h22, 8'h11}};
    vecs[2] = '{src: 8'hFE, dst: 8'h20, len: 9'd3, exp_done: 10, nexp: 3,
                exp: {8'h00, 8'hC3, 8'hB2, 8'hA1}};
    vecs[3] = '{src: 8'h30, dst: 8'h31, len: 9'd4, exp_done: 13, nexp: 4,
                exp: {8'h5A, 8'h5A, 8'h5A, 8'h5A}};
    vecs[4] = '{src: 8'h50, dst: 8'h60, len: 9'd0, exp_done: 1,  nexp: 0,
                exp: {8'h00, 8'h00, 8'h00, 8'h00}};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; length = 9'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_words", 32'(words_copied), 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_addr_din", 32'({mem_address, mem_din}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, 0, 0);
      chk($sformatf("v%0d_done_cycle", i), 32'(g_done_n), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_words", i), 32'(g_words), 32'(vecs[i].len));
      chk($sformatf("v%0d_aborted", i), 32'(g_aborted), 32'd0);
      chk($sformatf("v%0d_busy_cycles", i), 32'(g_busy_n), 32'(vecs[i].exp_done - 1));
      chk($sformatf("v%0d_reads", i), 32'(g_rd_n), 32'(vecs[i].len));
      chk($sformatf("v%0d_writes", i), 32'(g_wr_n), 32'(vecs[i].len));
      for (int j = 0; j < vecs[i].nexp; j++)
        chk($sformatf("v%0d_dst%0d", i, j), 32'(mem[8'(vecs[i].dst + j)]), 32'(vecs[i].exp[j]));
    end
    chk("v0_src_unchanged", 32'(mem[8'h02]), 32'h55);
    chk("v4_dst_untouched", 32'(mem[8'h60]), 32'h00);

    // Stray start pulses during WAIT and during DONE must be ignored.
    run_copy(8'h10, 8'h90, 9'd4, 0, 5);
    chk("pulse_busy_done", 32'(g_done_n), 32'd13);
    chk("pulse_busy_words", 32'(g_words), 32'd4);
    chk("pulse_busy_data", 32'({mem[8'h90], mem[8'h91], mem[8'h92], mem[8'h93]}), 32'h11223344);
    chk("pulse_busy_no41", 32'(mem[8'h41]), 32'h00);
    run_copy(8'h10, 8'h98, 9'd4, 0, 13);
    chk("pulse_done_cycle", 32'(g_done_n), 32'd13);
    busy_idle = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || mem_read) busy_idle++;
    end
    chk("pulse_done_ignored", 32'(busy_idle), 32'd0);

    // Abort sampled in WAIT of byte 3 (RD=7, WAIT=8).
    run_copy(8'hA0, 8'hB0, 9'd8, 8, 0);
    chk("abort_done_cycle", 32'(g_done_n), 32'd9);
    chk("abort_flag", 32'(g_aborted), 32'd1);
    chk("abort_words", 32'(g_words), 32'd2);
    chk("abort_writes", 32'(g_wr_n), 32'd2);
    chk("abort_dst", 32'({mem[8'hB0], mem[8'hB1], mem[8'hB2]}), 32'h0102EE);
    chk("abort_held", 32'(aborted), 32'd1);

    // Repeat run; reset asserted during the first WR (cycle 3).
    src_addr = 8'hA0; dst_addr = 8'hB0; length = 9'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("rerun_aborted_cleared", 32'(aborted), 32'd0);
    chk("rerun_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rerun_in_wr", 32'(mem_write), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("midrst_words", 32'(words_copied), 32'd0);
    chk("midrst_done_aborted", 32'({done, aborted}), 32'd0);
    reset = 1'b0;
    busy_idle = wr_mon;
    repeat (20) @(negedge clk);
    chk("midrst_no_writes", 32'(wr_mon - busy_idle), 32'd0);

    chk("never_rd_and_wr", 32'(conc_bad), 32'd0);
    chk("din_zero_outside_wr", 32'(din_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Memory-side initiator for the DataMemory port set (address, read, write, data_inputs, data_outputs): drives DataMemory instead of being driven by it.
- Copies a block of LEN bytes from SRC to DST inside one DataMemory instance, one byte at a time (read, wait, write).
- Sits beside the CPU datapath; the CPU hands over DataMemory through an external mux while busy=1.

Parameters:
ADDR_WIDTH, 8, width of DataMemory address and of src/dst pointers
DATA_WIDTH, 8, width of DataMemory data
READ_LATENCY, 1, cycles from the cycle mem_read is high to the edge at which mem_data_outputs is valid (must be >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request copy; sampled only in IDLE
abort  input  1  stop an in-progress copy; sampled only while busy
src_addr  input  ADDR_WIDTH  first source address, latched on accepted start
dst_addr  input  ADDR_WIDTH  first destination address, latched on accepted start
length  input  ADDR_WIDTH+1  byte count, 0..2^ADDR_WIDTH, latched on accepted start
busy  output  1  high from cycle after accepted start until DONE state
done  output  1  one-cycle pulse at end of copy (normal, zero-length or abort)
aborted  output  1  high with done when copy ended by abort; held until next accepted start
words_copied  output  ADDR_WIDTH+1  count of write cycles issued in current or last copy
mem_address  output  ADDR_WIDTH  to DataMemory address
mem_read  output  1  to DataMemory read
mem_write  output  1  to DataMemory write
mem_data_inputs  output  DATA_WIDTH  to DataMemory data_inputs
mem_data_outputs  input  DATA_WIDTH  from DataMemory data_outputs

Behaviour:
- All outputs registered. Reset: state IDLE; busy, done, aborted, mem_read, mem_write = 0; mem_address, mem_data_inputs, words_copied = 0; internal pointers, remaining count, data buffer = 0.
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE: mem_read = mem_write = 0. On start=1: latch src/dst/length, clear words_copied and aborted. If length=0, go to DONE with no memory access. Otherwise go to RD.
- RD (1 cycle): mem_address = src_ptr, mem_read=1, mem_write=0. Go to WAIT.
- WAIT (READ_LATENCY cycles): mem_read=0. On its last edge, capture mem_data_outputs into the buffer, then go to WR.
- WR (1 cycle): mem_address = dst_ptr, mem_data_inputs = buffer, mem_write=1, mem_read=0. On the edge leaving WR:
  - words_copied += 1; src_ptr += 1; dst_ptr += 1, both mod 2^ADDR_WIDTH (0xFF wraps to 0x00).
  - remaining -= 1. If remaining = 0, go to DONE; else go to RD.
- DONE (1 cycle): done=1, busy=0, memory strobes low. Then go to IDLE.
- Timing: each byte costs 2+READ_LATENCY cycles. With start accepted at edge E, done is high in the cycle beginning at edge E + length*(2+READ_LATENCY) + 1. A zero-length copy gives done in the cycle after E.
- mem_read and mem_write are never high in the same cycle.
- Outside WR, mem_data_inputs = 0. Outside RD/WR, mem_address holds its last value.
- start while busy or in DONE: ignored; no queueing.
- abort=1 sampled in RD, WAIT or WR: next state is DONE and aborted=1.
  - An access already issued in the current cycle completes; no further access is issued.
  - An abort sampled in a WR cycle still counts that write.
  - start and abort in the same IDLE cycle: start accepted, abort ignored.
- Overlapping regions: strict forward byte order, so each write is visible to later reads. Example: dst = src+1 replicates mem[src] across the whole block.
- length = 2^ADDR_WIDTH: copies the full memory with pointer wrap; words_copied ends at 256.
- reset mid-copy: IDLE in the next cycle with all outputs at reset values. No write is issued after the reset edge.

Test Plan:
- Preload mem[0x02]=0x55, mem[0x0A]=0xCC; start src=0x02, dst=0x40, length=1 -> one read at 0x02, write 0x55 to 0x40; done 4 cycles after start edge (READ_LATENCY=1); words_copied=1; mem[0x02] unchanged.
- Preload mem[0x10..0x13]=0x11,0x22,0x33,0x44; copy src=0x10, dst=0x80, length=4 -> mem[0x80..0x83] match; done at start+13; busy high 12 cycles; read/write never concurrent.
- Wrap: mem[0xFE]=0xA1, mem[0xFF]=0xB2, mem[0x00]=0xC3; copy src=0xFE, dst=0x20, length=3 -> mem[0x20..0x22]=0xA1,0xB2,0xC3.
- Overlap: mem[0x30]=0x5A; copy src=0x30, dst=0x31, length=4 -> mem[0x31..0x34] all 0x5A.
- length=0 -> done one cycle after start; no mem_read/mem_write; words_copied=0. A start pulse while busy in another copy -> ignored, that copy's result unchanged.
- Abort during WAIT of byte 3 of a length-8 copy -> done with aborted=1, words_copied=2, third destination byte unchanged. Reset asserted mid-WR on a repeat run -> next cycle busy=0, mem_write=0, words_copied=0.
